// File: rtl/rv32_mem_pkg.sv
// Shared encodings for the RV32 memory arbiter.
// Sizes, response owner tags and byte-enable constants.
package rv32_mem_pkg;

  localparam logic [2:0] SZ_B  = 3'b000;
  localparam logic [2:0] SZ_H  = 3'b001;
  localparam logic [2:0] SZ_W  = 3'b010;
  localparam logic [2:0] SZ_BU = 3'b100;
  localparam logic [2:0] SZ_HU = 3'b101;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_FETCH,
    OWN_DATA,
    OWN_DERR
  } owner_e;

  localparam logic [3:0] BE_NONE = 4'b0000;
  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_ALL  = 4'b1111;

  // Stores accept only B/H/W; halves need even
  // offsets and words need offset zero.
  function automatic logic is_legal(
    input logic       we,
    input logic [2:0] size,
    input logic [1:0] off
  );
    logic ok;
    ok = 1'b0;
    case (size)
      SZ_B:    ok = 1'b1;
      SZ_BU:   ok = !we;
      SZ_H:    ok = !off[0];
      SZ_HU:   ok = !we && !off[0];
      SZ_W:    ok = (off == 2'd0);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/rv32_lsu_align.sv
// Sub-word formatting for the data port.
// Store lane placement, load extract/extend, legality.
module rv32_lsu_align
  import rv32_mem_pkg::*;
(
  input  logic        rq_we,
  input  logic [2:0]  rq_size,
  input  logic [1:0]  rq_off,
  input  logic [31:0] rq_wdata,
  output logic        rq_legal,
  output logic [3:0]  rq_be,
  output logic [31:0] rq_wlane,
  input  logic [2:0]  rs_size,
  input  logic [1:0]  rs_off,
  input  logic [31:0] rs_raw,
  output logic [31:0] rs_data
);

  logic [31:0] rs_sh;

  // Request side: legality, store enables and lanes.
  always_comb begin
    rq_legal = is_legal(rq_we, rq_size, rq_off);
    rq_be    = BE_ALL;
    rq_wlane = '0;
    if (rq_we) begin
      case (rq_size)
        SZ_B: begin
          rq_be    = BE_BYTE << rq_off;
          rq_wlane = {4{rq_wdata[7:0]}};
        end
        SZ_H: begin
          rq_be    = BE_HALF << rq_off;
          rq_wlane = {2{rq_wdata[15:0]}};
        end
        SZ_W: begin
          rq_be    = BE_ALL;
          rq_wlane = rq_wdata;
        end
        default: rq_be = BE_NONE;
      endcase
    end
  end

  // Response side: shift lane down, then extend.
  always_comb begin
    rs_sh = rs_raw >> {rs_off, 3'b000};
    case (rs_size)
      SZ_B:  rs_data = {{24{rs_sh[7]}}, rs_sh[7:0]};
      SZ_BU: rs_data = {24'h0, rs_sh[7:0]};
      SZ_H:  rs_data = {{16{rs_sh[15]}}, rs_sh[15:0]};
      SZ_HU: rs_data = {16'h0, rs_sh[15:0]};
      default: rs_data = rs_raw;
    endcase
  end

endmodule

// File: rtl/rv32_mem_arbiter.sv
// Fetch/data arbiter for a shared single-port RAM.
// Data has priority; a streak limit bounds fetch wait.
module rv32_mem_arbiter
  import rv32_mem_pkg::*;
#(
  parameter int AW           = 12,
  parameter int MAX_D_STREAK = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_req,
  input  logic [31:0]   i_addr,
  output logic          i_gnt,
  output logic          i_rvalid,
  output logic [31:0]   i_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [2:0]    d_size,
  input  logic [31:0]   d_addr,
  input  logic [31:0]   d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [31:0]   d_rdata,
  output logic          d_err,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [3:0]    mem_be,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata
);

  localparam int SW = $clog2(MAX_D_STREAK + 1);
  localparam logic [SW-1:0] SMAX =
    SW'(MAX_D_STREAK);

  logic [SW-1:0] streak;
  owner_e        owner;
  owner_e        owner_nx;
  logic [2:0]    rs_size;
  logic [1:0]    rs_off;
  logic          rs_we;
  logic          d_win;
  logic          rq_legal;
  logic [3:0]    rq_be;
  logic [31:0]   rq_wlane;
  logic [31:0]   rs_data;
  logic          unused_hi;

  assign unused_hi = ^{i_addr[31:AW],
                       d_addr[31:AW+2]};

  rv32_lsu_align u_align (
    .rq_we    (d_we),
    .rq_size  (d_size),
    .rq_off   (d_addr[1:0]),
    .rq_wdata (d_wdata),
    .rq_legal (rq_legal),
    .rq_be    (rq_be),
    .rq_wlane (rq_wlane),
    .rs_size  (rs_size),
    .rs_off   (rs_off),
    .rs_raw   (mem_rdata),
    .rs_data  (rs_data)
  );

  // Same-cycle grant; fetch wins only at full streak.
  always_comb begin
    d_win = d_req && !(i_req && streak == SMAX);
    d_gnt = !rst && d_win;
    i_gnt = !rst && i_req && !d_win;
  end

  // Drive the RAM port for whichever side won.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_be    = BE_NONE;
    mem_wdata = '0;
    unique case (1'b1)
      i_gnt: begin
        mem_en   = 1'b1;
        mem_addr = i_addr[AW-1:0];
        mem_be   = BE_ALL;
      end
      d_gnt: begin
        if (rq_legal) begin
          mem_en   = 1'b1;
          mem_we   = d_we;
          mem_addr = d_addr[AW+1:2];
          mem_be   = d_we ? rq_be : BE_ALL;
          if (d_we) mem_wdata = rq_wlane;
        end
      end
      default: ;
    endcase
  end

  // Count data grants that a waiting fetch lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      streak <= '0;
    end else if (!i_req || i_gnt) begin
      streak <= '0;
    end else if (d_gnt && streak != SMAX) begin
      streak <= streak + 1'b1;
    end
  end

  // Tag the response that the next cycle carries.
  always_comb begin
    owner_nx = OWN_NONE;
    unique case (1'b1)
      i_gnt: owner_nx = OWN_FETCH;
      d_gnt: owner_nx = rq_legal ? OWN_DATA
                                 : OWN_DERR;
      default: ;
    endcase
  end

  // Outstanding tracker: owner plus load format.
  always_ff @(posedge clk) begin
    if (rst) begin
      owner   <= OWN_NONE;
      rs_size <= '0;
      rs_off  <= '0;
      rs_we   <= 1'b0;
    end else begin
      owner <= owner_nx;
      if (d_gnt) begin
        rs_size <= d_size;
        rs_off  <= d_addr[1:0];
        rs_we   <= d_we;
      end
    end
  end

  // Route the RAM data to the owning port; reset
  // squashes any response still in flight.
  always_comb begin
    i_rvalid = 1'b0;
    i_rdata  = '0;
    d_rvalid = 1'b0;
    d_rdata  = '0;
    d_err    = 1'b0;
    if (!rst) begin
      case (owner)
        OWN_FETCH: begin
          i_rvalid = 1'b1;
          i_rdata  = mem_rdata;
        end
        OWN_DATA: begin
          d_rvalid = 1'b1;
          if (!rs_we) d_rdata = rs_data;
        end
        OWN_DERR: begin
          d_rvalid = 1'b1;
          d_err    = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rv32_mem_arbiter.sv
// Scoreboard bench for rv32_mem_arbiter.
// Byte-level reference memory, directed + random traffic.
module tb_rv32_mem_arbiter;
  import rv32_mem_pkg::*;

  localparam int AW   = 12;
  localparam int MAXS = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          i_req, i_gnt, i_rvalid;
  logic [31:0]   i_addr, i_rdata;
  logic          d_req, d_we, d_gnt, d_rvalid, d_err;
  logic [2:0]    d_size;
  logic [31:0]   d_addr, d_wdata, d_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [3:0]    mem_be;
  logic [31:0]   mem_wdata, mem_rdata;

  rv32_mem_arbiter #(.AW(AW), .MAX_D_STREAK(MAXS)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt),
    .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_size(d_size),
    .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt),
    .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  logic [31:0] ram [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we)
        for (int b = 0; b < 4; b++)
          if (mem_be[b])
            ram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      mem_rdata <= ram[mem_addr];
    end
  end

  logic [7:0] rb [0:(4<<AW)-1];

  typedef struct packed {
    logic        fetch;
    logic        err;
    logic [31:0] data;
  } rsp_t;
  rsp_t q[$];
  rsp_t mon_e;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t",
               name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      chk("rv_excl", 32'(i_rvalid && d_rvalid), 32'd0);
      if (i_rvalid || d_rvalid) begin
        if (q.size() == 0) begin
          n_chk++; n_err++;
          $display("FAIL rsp_unexpected: i_rvalid=%b d_rvalid=%b at %0t",
                   i_rvalid, d_rvalid, $time);
        end else begin
          mon_e = q.pop_front();
          chk("rsp_kind", 32'(i_rvalid), 32'(mon_e.fetch));
          chk("rsp_data", mon_e.fetch ? i_rdata : d_rdata, mon_e.data);
          chk("rsp_err", 32'(d_err), 32'(mon_e.err));
        end
      end
    end
  end

  bit          fi_pend, dr_pend, dr_we, prev_g;
  logic [31:0] fi_addr, dr_addr, dr_wdata;
  logic [2:0]  dr_size;
  logic [1:0]  last_g;
  int          streak_m, fwait, dwait;

  function automatic bit legal_m(bit we, logic [2:0] sz, logic [1:0] off);
    bit even, zero;
    even = (off[0] == 1'b0);
    zero = (off == 2'd0);
    if (we)
      return sz == SZ_B || (sz == SZ_H && even) || (sz == SZ_W && zero);
    return sz == SZ_B || sz == SZ_BU ||
           ((sz == SZ_H || sz == SZ_HU) && even) ||
           (sz == SZ_W && zero);
  endfunction

  function automatic logic [31:0] rd_word(int wa);
    return {rb[4*wa+3], rb[4*wa+2], rb[4*wa+1], rb[4*wa]};
  endfunction

  task automatic data_rsp(output rsp_t r);
    int ba;
    ba = int'(dr_addr[AW+1:0]);
    r = '0;
    if (!legal_m(dr_we, dr_size, dr_addr[1:0])) begin
      r.err = 1'b1;
    end else if (dr_we) begin
      for (int k = 0; k < 4; k++)
        if (dr_size == SZ_W || (dr_size == SZ_H && k < 2) || k == 0)
          rb[ba+k] = dr_wdata[8*k +: 8];
    end else begin
      case (dr_size)
        SZ_B:  r.data = 32'($signed(rb[ba]));
        SZ_BU: r.data = 32'(rb[ba]);
        SZ_H:  r.data = 32'($signed({rb[ba+1], rb[ba]}));
        SZ_HU: r.data = 32'({rb[ba+1], rb[ba]});
        default: r.data = rd_word(ba / 4);
      endcase
    end
  endtask

  task automatic step();
    rsp_t        r;
    bit          ei, ed, ip;
    int          off;
    logic [3:0]  ebe;
    logic [31:0] ewd;
    i_req = fi_pend; i_addr = fi_addr;
    d_req = dr_pend; d_we = dr_we; d_size = dr_size;
    d_addr = dr_addr; d_wdata = dr_wdata;
    ip = fi_pend;
    @(negedge clk);
    ed = dr_pend && !(fi_pend && streak_m == MAXS);
    ei = fi_pend && !ed;
    chk("gnt", 32'({i_gnt, d_gnt}), 32'({ei, ed}));
    chk("rsp_timing", 32'(i_rvalid || d_rvalid), 32'(prev_g));
    last_g = {i_gnt, d_gnt};
    if (fi_pend) fwait++;
    if (dr_pend) dwait++;
    if (ei) begin
      chk("f_bus", 32'({mem_en, mem_we, mem_be}), 32'(6'b10_1111));
      chk("f_addr", 32'(mem_addr), 32'(fi_addr[AW-1:0]));
      chk("fetch_wait", 32'(fwait <= MAXS + 1), 32'd1);
      r = '{fetch: 1'b1, err: 1'b0,
            data: rd_word(int'(fi_addr[AW-1:0]))};
      q.push_back(r);
      fi_pend = 0; fwait = 0;
    end else if (ed) begin
      chk("data_wait", 32'(dwait <= 2), 32'd1);
      if (legal_m(dr_we, dr_size, dr_addr[1:0])) begin
        off = int'(dr_addr[1:0]);
        ebe = 4'hF; ewd = dr_wdata;
        if (dr_we && dr_size == SZ_B) begin
          ebe = 4'(1 << off); ewd = {4{dr_wdata[7:0]}};
        end else if (dr_we && dr_size == SZ_H) begin
          ebe = 4'(3 << off); ewd = {2{dr_wdata[15:0]}};
        end
        chk("d_en_we", 32'({mem_en, mem_we}), 32'({1'b1, dr_we}));
        chk("d_addr", 32'(mem_addr), 32'(dr_addr[AW+1:2]));
        chk("d_be", 32'(mem_be), 32'(ebe));
        if (dr_we) chk("d_wdata", mem_wdata, ewd);
      end else begin
        chk("err_no_en", 32'(mem_en), 32'd0);
      end
      data_rsp(r);
      q.push_back(r);
      dr_pend = 0; dwait = 0;
    end else begin
      chk("idle_bus", 32'({mem_en, mem_we, mem_be}), 32'd0);
      chk("idle_addr", 32'(mem_addr) | mem_wdata, 32'd0);
    end
    if (!ip || ei) streak_m = 0;
    else if (ed && streak_m < MAXS) streak_m++;
    prev_g = ei || ed;
    @(posedge clk); #1;
  endtask

  task automatic set_d(input bit we, input logic [2:0] sz,
                       input logic [31:0] a, input logic [31:0] wd);
    dr_pend = 1; dr_we = we; dr_size = sz;
    dr_addr = a; dr_wdata = wd;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while ((fi_pend || dr_pend) && guard < 50) begin
      step(); guard++;
    end
    if (fi_pend || dr_pend) begin
      n_chk++; n_err++;
      $display("FAIL drain_timeout: fi=%b dr=%b", fi_pend, dr_pend);
      fi_pend = 0; dr_pend = 0;
    end
    step(); step();
  endtask

  logic [2:0]  szt [10];
  logic [31:0] w;

  initial begin
    szt = '{SZ_B, SZ_H, SZ_W, SZ_BU, SZ_HU,
            SZ_B, SZ_H, SZ_W, 3'b011, 3'b111};
    for (int wa = 0; wa < (1 << AW); wa++) begin
      w = (wa == 5) ? 32'h00500093 : $urandom;
      ram[wa] <= w;
      for (int b = 0; b < 4; b++) rb[4*wa+b] = w[8*b +: 8];
    end
    fi_pend = 0; dr_pend = 0; fi_addr = 0;
    dr_we = 0; dr_size = 0; dr_addr = 0; dr_wdata = 0;
    streak_m = 0; fwait = 0; dwait = 0; prev_g = 0;
    rst = 1; i_req = 1; i_addr = 0; d_req = 1;
    d_we = 0; d_size = SZ_W; d_addr = 0; d_wdata = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_gnt", 32'({i_gnt, d_gnt}), 32'd0);
    chk("rst_rv", 32'({i_rvalid, d_rvalid, d_err}), 32'd0);
    chk("rst_rdata", i_rdata | d_rdata, 32'd0);
    chk("rst_mem", 32'({mem_en, mem_we, mem_be}), 32'd0);
    chk("rst_maddr", 32'(mem_addr) | mem_wdata, 32'd0);
    @(posedge clk); #1;
    rst = 0;

    fi_pend = 1; fi_addr = 32'd5;
    step(); step();

    set_d(1, SZ_B, 32'h13, 32'hAB); step();
    set_d(0, SZ_B, 32'h13, 32'h0); step();
    set_d(0, SZ_BU, 32'h13, 32'h0); step();
    set_d(0, SZ_H, 32'h3, 32'h0); step();
    set_d(0, SZ_W, 32'h2, 32'h0); step();
    step();

    for (int k = 0; k < 15; k++) begin
      fi_pend = 1; fi_addr = $urandom_range(0, 63);
      if (!dr_pend)
        set_d(0, SZ_W, 32'($urandom_range(0, 63)) << 2, 32'h0);
      step();
      chk("dddi_pattern", 32'(last_g),
          (k % 5 == 4) ? 32'd2 : 32'd1);
    end
    fi_pend = 0;
    drain();

    set_d(0, SZ_W, 32'h40, 32'h0); step();
    set_d(1, SZ_W, 32'h44, 32'hCAFE_F00D); step();
    fi_pend = 1; fi_addr = 32'd17; step();
    step(); step();

    set_d(0, SZ_W, 32'h48, 32'h0); step();
    rst = 1; q.delete();
    set_d(0, SZ_H, 32'h4A, 32'h0);
    i_req = 1; d_req = 1; d_size = SZ_H; d_addr = 32'h4A;
    @(negedge clk);
    chk("rstmid_gnt", 32'({i_gnt, d_gnt}), 32'd0);
    chk("rstmid_rv", 32'({i_rvalid, d_rvalid, d_err}), 32'd0);
    chk("rstmid_data", i_rdata | d_rdata, 32'd0);
    chk("rstmid_mem", 32'({mem_en, mem_we, mem_be}), 32'd0);
    @(posedge clk); #1;
    rst = 0; streak_m = 0; prev_g = 0; fwait = 0; dwait = 0;
    step();
    drain();

    for (int c = 0; c < 2000; c++) begin
      if (!fi_pend && $urandom_range(0, 99) < 50) begin
        fi_pend = 1;
        fi_addr = 32'($urandom_range(0, 63));
        if ($urandom_range(0, 3) == 0) fi_addr |= $urandom << AW;
      end
      if (!dr_pend && $urandom_range(0, 99) < 60) begin
        set_d(1'($urandom_range(0, 1)), szt[$urandom_range(0, 9)],
              32'($urandom_range(0, 255)), $urandom);
        if ($urandom_range(0, 3) == 0)
          dr_addr |= $urandom << (AW + 2);
      end
      step();
    end
    drain();
    chk("q_empty", 32'(q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/rv32_mem_arbiter.md
# rv32_mem_arbiter

Shares one single-port synchronous data/instruction RAM between the RV32I core's instruction-fetch port and its load/store port. Grants one access per cycle, giving data priority and preventing fetch starvation with a streak limit. Also performs RV32I sub-word formatting: store byte-lane placement and byte enables, load lane extraction and sign/zero extension, and misalignment detection. Sits between the core and the RAM macro.

## Interface
Parameters:
- AW, 12, RAM word-address width (RAM depth 2^AW words of 32 bits)
- MAX_D_STREAK, 4, max consecutive data grants while a fetch is pending (≥1)

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- i_req  in  1  fetch request
- i_addr  in  32  fetch word index (pc units of one word); bits [AW-1:0] used
- i_gnt  out  1  fetch accepted this cycle
- i_rvalid  out  1  fetch data valid
- i_rdata  out  32  fetched instruction
- d_req  in  1  load/store request
- d_we  in  1  1 = store
- d_size  in  3  RV32I funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU)
- d_addr  in  32  byte address
- d_wdata  in  32  store data, LSB-aligned
- d_gnt  out  1  data request accepted this cycle
- d_rvalid  out  1  load data / store completion valid
- d_rdata  out  32  formatted load data (0 for stores and errors)
- d_err  out  1  misaligned or illegal size, valid with d_rvalid
- mem_en  out  1  RAM access enable
- mem_we  out  1  RAM write
- mem_addr  out  AW  RAM word address
- mem_be  out  4  byte enables
- mem_wdata  out  32  lane-placed write data
- mem_rdata  in  32  RAM read data, one cycle after mem_en

## Operation
- Requester holds req and all request fields stable until gnt; may drop or change them the cycle after gnt.
- Grant (combinational, same cycle): only d_req → data; only i_req → fetch; both → data unless streak == MAX_D_STREAK, then fetch.
- Streak counter: +1 on each data grant while i_req=1; cleared on fetch grant or whenever i_req=0; saturates at MAX_D_STREAK.
- Fetch grant: mem_en=1, mem_we=0, mem_addr=i_addr[AW-1:0], mem_be=4'hF.
- Data grant: mem_addr=d_addr[AW+1:2]; byte offset off=d_addr[1:0].
- Legal: B any off; H/HU off∈{0,2}; W off=0; stores only B/H/W. Otherwise error: no RAM access (mem_en=0), d_rvalid+d_err next cycle, d_rdata=0.
- Store: mem_we=1; B → mem_be=1<<off, byte replicated to all lanes; H → mem_be=4'b0011<<off, halfword replicated; W → 4'hF.
- Load: mem_be=4'hF; off and size registered at grant; response lane = mem_rdata >> (8*off), sign-extended for B/H, zero-extended for BU/HU.
- Outstanding tracker: registered owner ∈ {NONE, FETCH, DATA, DATA_ERR} plus off/size/we; one response per grant.
- No grant: mem_en=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0.

## Timing
- Grant in cycle N → RAM sampled at edge end of N → i_rvalid/d_rvalid asserted in N+1 with data; fully pipelined, new grant allowed in N+1 (one grant per cycle throughput).
- Exactly one of i_rvalid/d_rvalid per cycle at most; each a single-cycle pulse.
- Store: d_rvalid in N+1, d_rdata=0, d_err=0.
- Reset values: i_gnt=d_gnt=0 while rst=1; i_rvalid=d_rvalid=d_err=0; i_rdata=d_rdata=0; all mem_* =0; streak=0; owner=NONE.
- Reset mid-operation: outstanding response discarded; no rvalid in the cycle after rst deasserts.
- Fetch starvation bound: fetch granted within MAX_D_STREAK+1 cycles of i_req assertion.

## Structure
- Package rv32_mem_pkg: size encodings (SZ_B, SZ_H, SZ_W, SZ_BU, SZ_HU), owner enum, byte-enable constants.
- Sub-module rv32_lsu_align: combinational store lane placement/byte enables, load extract/extend, misalign check; arbiter instantiates it once.

## Test plan
- Fetch only, i_addr=5, RAM[5]=32'h00500093 → i_gnt cycle N, i_rvalid+i_rdata=32'h00500093 in N+1.
- SB d_addr=0x0000_0013, d_wdata=0xAB → mem_addr=4, mem_be=4'b1000, mem_wdata=0xABABABAB; then LB same addr → d_rdata=0xFFFF_FFAB, LBU → 0x0000_00AB.
- LH d_addr=0x0000_0003 → no mem_en, d_rvalid+d_err next cycle, d_rdata=0; LW at 0x2 also errors.
- i_req and d_req held high continuously, MAX_D_STREAK=4 → grant pattern D,D,D,D,I repeating; responses in matching order one cycle later.
- Back-to-back LW then SW then fetch on consecutive cycles → three responses in consecutive cycles, no bubbles.
- rst asserted the cycle after a load grant → no d_rvalid; all outputs 0 next cycle; first grant after reset responds normally.
